// File: rtl/a4092_pkg.sv
// Shared definitions for the A4092 Zorro III slave logic: cycle-termination
// state encoding, DTACK request source indices and the default watchdog limit.
package a4092_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_DS  = 3'd1;
    localparam state_t ST_WAIT_ACK = 3'd2;
    localparam state_t ST_ACK      = 3'd3;
    localparam state_t ST_RELEASE  = 3'd4;

    localparam int unsigned SRC_SCSI = 0;
    localparam int unsigned SRC_AC   = 1;
    localparam int unsigned SRC_ROM  = 2;
    localparam int unsigned NUM_SRC  = 3;

endpackage

// File: rtl/cycle_watchdog.sv
// 8-bit saturating cycle counter with synchronous clear and a terminal-count
// flag that fires when the count reaches TIMEOUT-1.
module cycle_watchdog
    import a4092_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam logic [7:0] TERM_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == TERM_COUNT);

endmodule

// File: rtl/z3_cycle_term.sv
// Zorro III slave-cycle termination: merges region DTACK requests into the
// bus-facing DTACK_n/DOE handshake, with release, abort and watchdog timeout.
module z3_cycle_term
    import a4092_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       FCS_n,
    input  logic [3:0] DS_n,
    input  logic       READ,
    input  logic       slave_cycle,
    input  logic       scsi_dtack,
    input  logic       ac_dtack,
    input  logic       rom_dtack,
    input  logic       err_clr,
    output logic       DTACK_n,
    output logic       dtack_oe,
    output logic       DOE,
    output logic       cycle_active,
    output logic       timeout_err
);

    logic [NUM_SRC-1:0] dtack_req;
    logic               ack;
    logic               ds_any;

    state_t state_q, state_d;
    logic   timeout_hit;
    logic   wd_clr, wd_en, wd_terminal;

    logic dtack_n_q, dtack_n_d;
    logic dtack_oe_q, dtack_oe_d;
    logic doe_q, doe_d;
    logic cycle_active_q, cycle_active_d;
    logic timeout_err_q, timeout_err_d;

    always_comb begin
        dtack_req           = '0;
        dtack_req[SRC_SCSI] = scsi_dtack;
        dtack_req[SRC_AC]   = ac_dtack;
        dtack_req[SRC_ROM]  = rom_dtack;
    end

    assign ack    = |dtack_req;
    assign ds_any = ~&DS_n;

    // FCS_n high always wins: an abort beats both ack and the watchdog.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!FCS_n && slave_cycle) state_d = ST_WAIT_DS;
            end
            ST_WAIT_DS: begin
                if (FCS_n)       state_d = ST_RELEASE;
                else if (ds_any) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (FCS_n) begin
                    state_d = ST_RELEASE;
                end else if (ack) begin
                    state_d = ST_ACK;
                end else if (wd_terminal) begin
                    state_d     = ST_ACK;
                    timeout_hit = 1'b1;
                end
            end
            ST_ACK: begin
                if (FCS_n) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wd_clr = (state_d == ST_WAIT_ACK) && (state_q != ST_WAIT_ACK);
    assign wd_en  = (state_q == ST_WAIT_ACK);

    cycle_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .clr      (wd_clr),
        .en       (wd_en),
        .terminal (wd_terminal)
    );

    // DTACK_n and the pad enable trail the state by one clock, so the bus sees
    // DTACK one cycle after ack and one driven-high cycle after release.
    always_comb begin
        dtack_n_d  = (state_q != ST_ACK);
        dtack_oe_d = (state_d == ST_WAIT_ACK) ||
                     (state_q inside {ST_WAIT_ACK, ST_ACK, ST_RELEASE});

        if ((state_q == ST_WAIT_DS) && (state_d == ST_WAIT_ACK)) begin
            doe_d = READ;
        end else if (state_d inside {ST_WAIT_ACK, ST_ACK}) begin
            doe_d = doe_q;
        end else begin
            doe_d = 1'b0;
        end

        cycle_active_d = (state_q == ST_IDLE) ? (state_d == ST_WAIT_DS) : 1'b1;

        if (timeout_hit)  timeout_err_d = 1'b1;
        else if (err_clr) timeout_err_d = 1'b0;
        else              timeout_err_d = timeout_err_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q        <= ST_IDLE;
            dtack_n_q      <= 1'b1;
            dtack_oe_q     <= 1'b0;
            doe_q          <= 1'b0;
            cycle_active_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            dtack_n_q      <= dtack_n_d;
            dtack_oe_q     <= dtack_oe_d;
            doe_q          <= doe_d;
            cycle_active_q <= cycle_active_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign DTACK_n      = dtack_n_q;
    assign dtack_oe     = dtack_oe_q;
    assign DOE          = doe_q;
    assign cycle_active = cycle_active_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_z3_cycle_term.sv
// Bench for z3_cycle_term: transaction-level model predicts per-cycle output
// profiles; a monitor measures each bus cycle and compares against the queue.
module tb_z3_cycle_term;
    import a4092_pkg::*;

    localparam int unsigned TMO = 8;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       FCS_n;
    logic [3:0] DS_n;
    logic       READ;
    logic       slave_cycle;
    logic       scsi_dtack, ac_dtack, rom_dtack;
    logic       err_clr;
    logic       DTACK_n, dtack_oe, DOE, cycle_active, timeout_err;

    z3_cycle_term #(
        .TIMEOUT (TMO)
    ) dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .FCS_n        (FCS_n),
        .DS_n         (DS_n),
        .READ         (READ),
        .slave_cycle  (slave_cycle),
        .scsi_dtack   (scsi_dtack),
        .ac_dtack     (ac_dtack),
        .rom_dtack    (rom_dtack),
        .err_clr      (err_clr),
        .DTACK_n      (DTACK_n),
        .dtack_oe     (dtack_oe),
        .DOE          (DOE),
        .cycle_active (cycle_active),
        .timeout_err  (timeout_err)
    );

    always #5 CLK = ~CLK;

    // Expected profile of one bus cycle, counted in samples where cycle_active=1.
    typedef struct {
        bit is_reset;
        int pre;   // dtack_oe high before DTACK_n first goes low
        int low;   // DTACK_n low
        int doe;   // DOE high
        int oe;    // dtack_oe high
        int act;   // cycle_active high
        bit err;   // timeout_err at the end of the cycle
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    bit   done = 0;
    bit   mon_done = 0;
    bit   err_model = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: measures each cycle_active window and checks idle outputs.
    initial begin
        bit   in_cyc;
        bit   seen_low;
        int   c_pre, c_low, c_doe, c_oe, c_act;
        exp_t x;
        in_cyc = 0;
        seen_low = 0;
        c_pre = 0; c_low = 0; c_doe = 0; c_oe = 0; c_act = 0;
        while (!done) begin
            @(posedge CLK);
            #1;
            if (cycle_active === 1'b1) begin
                if (!in_cyc) begin
                    in_cyc = 1; seen_low = 0;
                    c_pre = 0; c_low = 0; c_doe = 0; c_oe = 0; c_act = 0;
                end
                c_act++;
                if (dtack_oe === 1'b1) c_oe++;
                if (DOE === 1'b1) c_doe++;
                if (DTACK_n === 1'b0) begin
                    c_low++;
                    seen_low = 1;
                end else if (dtack_oe === 1'b1 && !seen_low) begin
                    c_pre++;
                end
            end else begin
                if (in_cyc) begin
                    in_cyc = 0;
                    if (q.size() == 0) begin
                        chk("unexpected_cycle", 1, 0);
                    end else begin
                        x = q.pop_front();
                        if (!x.is_reset) begin
                            chk("ack_latency", c_pre, x.pre);
                            chk("dtack_low_len", c_low, x.low);
                            chk("doe_len", c_doe, x.doe);
                            chk("dtack_oe_len", c_oe, x.oe);
                            chk("active_len", c_act, x.act);
                        end
                        chk("end_timeout_err", int'(timeout_err), int'(x.err));
                    end
                end
                chk("idle_outputs", int'({DTACK_n, dtack_oe, DOE}), 4);
            end
        end
        chk("queue_drained", q.size(), 0);
        mon_done = 1;
    end

    task automatic set_idle();
        FCS_n = 1'b1; slave_cycle = 1'b0; DS_n = 4'hF; READ = 1'b0;
        scsi_dtack = 1'b0; ac_dtack = 1'b0; rom_dtack = 1'b0;
    endtask

    task automatic set_acks(input bit v, input int src);
        scsi_dtack = v && (src == SRC_SCSI);
        ac_dtack   = v && (src == SRC_AC);
        rom_dtack  = v && (src == SRC_ROM);
    endtask

    // One master cycle. Edge 0 claims; DS_n low from edge dsd; ack sampled from
    // edge dsd+j (j=0: never); b>0 raises FCS_n b edges after WAIT_ACK entry;
    // otherwise FCS_n is held h extra edges after DTACK_n appears.
    task automatic run_txn(input bit rd, input int src, input int dsd, input int j,
                           input int b, input int h);
        int   r, lat;
        bit   to;
        exp_t x;
        logic [3:0] ds_low;
        ds_low = 4'($urandom_range(0, 14));
        x.is_reset = 0;
        if (b != 0) begin
            r = dsd + b;
            x.pre = b + 2; x.low = 0; x.doe = rd ? b : 0;
            x.oe = b + 2; x.act = dsd + b + 2;
            to = 0;
        end else begin
            to  = !(j != 0 && j <= int'(TMO));
            lat = to ? int'(TMO) + 1 : j + 1;
            r = dsd + lat + h;
            x.pre = lat; x.low = h + 1; x.doe = rd ? lat + h : 0;
            x.oe = lat + h + 2; x.act = dsd + lat + h + 2;
        end
        err_model = err_model | to;
        x.err = err_model;
        q.push_back(x);
        for (int e = 0; e <= r + 2; e++) begin
            @(negedge CLK);
            if (e < r) begin
                FCS_n = 1'b0; slave_cycle = 1'b1; READ = rd;
                DS_n = (e >= dsd) ? ds_low : 4'hF;
                // j=1 raises ack already at the WAIT_ACK entry edge
                set_acks(j != 0 && b == 0 && e >= dsd + j - ((j == 1) ? 1 : 0), src);
            end else begin
                set_idle();
            end
        end
    endtask

    task automatic clear_err();
        @(negedge CLK); err_clr = 1'b1; err_model = 0;
        @(negedge CLK); err_clr = 1'b0;
    endtask

    task automatic not_selected();
        for (int e = 0; e < 6; e++) begin
            @(negedge CLK);
            FCS_n = 1'b0; slave_cycle = 1'b0; DS_n = 4'h0; READ = 1'b1;
            set_acks(1'b1, SRC_SCSI);
        end
        @(negedge CLK); set_idle();
        repeat (2) @(negedge CLK);
    endtask

    // Reset asserted while the cycle is in ACK with DTACK_n driven low.
    task automatic reset_in_ack();
        exp_t x;
        x = '{is_reset: 1, pre: 0, low: 0, doe: 0, oe: 0, act: 0, err: 0};
        q.push_back(x);
        for (int e = 0; e < 5; e++) begin
            @(negedge CLK);
            FCS_n = 1'b0; slave_cycle = 1'b1; READ = 1'b1;
            DS_n = (e >= 1) ? 4'h0 : 4'hF;
            set_acks(e >= 2, SRC_SCSI);
        end
        @(negedge CLK); RESET_n = 1'b0; set_idle();
        @(negedge CLK); RESET_n = 1'b1; err_model = 0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        RESET_n = 1'b0; err_clr = 1'b0;
        set_idle();
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        run_txn(1, SRC_SCSI, 1, 3, 0, 2);   // SCSI read
        run_txn(0, SRC_AC,   2, 2, 0, 1);   // autoconfig write
        run_txn(1, SRC_ROM,  1, 0, 0, 1);   // no ack: watchdog
        clear_err();
        run_txn(0, SRC_SCSI, 1, 0, 0, 0);   // timeout, err left set
        run_txn(1, SRC_SCSI, 1, 0, 3, 0);   // abort keeps err
        run_txn(0, SRC_AC,   3, 1, 0, 0);   // ack present on entry
        run_txn(1, SRC_ROM,  1, int'(TMO), 0, 1); // ack on the terminal count
        not_selected();
        run_txn(1, SRC_AC,   2, 0, 0, 0);
        reset_in_ack();

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) clear_err();
            if ($urandom_range(0, 4) == 0) begin
                run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                        int'($urandom_range(1, 3)), 0, int'($urandom_range(1, TMO)), 0);
            end else begin
                run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                        int'($urandom_range(1, 3)), int'($urandom_range(0, 12)), 0,
                        int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (4) @(negedge CLK);
        done = 1;
        repeat (3) @(negedge CLK);
        if (!mon_done) $display("FAIL monitor_exit: monitor still running");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
